// File: rtl/serial_loader.sv
// serial_loader: serial-to-parallel RAM loader; define SERIAL_LOADER_PARITY_EN to add an even-parity bit per word
module serial_loader #(
   parameter int DATA_WIDTH = 192,
   parameter int ADDR_WIDTH = 11,
   parameter int NUM_DP     = 5,
   parameter bit MSB_FIRST  = 1'b0
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  start,
   input  logic                  ser,
   input  logic                  ser_valid,
   output logic                  we,
   output logic [ADDR_WIDTH-1:0] addr,
   output logic [DATA_WIDTH-1:0] data,
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_WIDTH:0]   word_cnt,
   output logic                  par_err
);
   localparam int CW = $clog2(DATA_WIDTH + 1);
   localparam int IW = $clog2(DATA_WIDTH);
   localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);
   localparam logic [ADDR_WIDTH:0] LAST_WORD = (ADDR_WIDTH + 1)'(NUM_DP - 1);
`ifdef SERIAL_LOADER_PARITY_EN
   typedef enum logic [2:0] {IDLE, SHIFT, PARITY, WRITE, DONE} state_t;
`else
   typedef enum logic [2:0] {IDLE, SHIFT, WRITE, DONE} state_t;
`endif
   state_t                state_q;
   logic [CW-1:0]         cnt_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic [ADDR_WIDTH:0]   word_cnt_q;
   logic                  we_q, busy_q, done_q, par_err_q;
   logic [IW-1:0]         idx;
   assign idx = IW'(MSB_FIRST ? LAST - cnt_q : cnt_q);
   // word with the current serial bit dropped into its slot
   always_comb begin
      data_d = data_q;
      data_d[idx] = ser;
   end
   // load FSM; every output is a register so we/addr/data are glitch-free to the RAM
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         addr_q     <= '0;
         data_q     <= '0;
         word_cnt_q <= '0;
         we_q       <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         par_err_q  <= 1'b0;
      end else begin
         we_q      <= 1'b0;
         par_err_q <= 1'b0;
         case (state_q)
            IDLE, DONE: if (start) begin
               state_q    <= SHIFT;
               cnt_q      <= '0;
               addr_q     <= '0;
               word_cnt_q <= '0;
               done_q     <= 1'b0;
               busy_q     <= 1'b1;
            end
            SHIFT: if (ser_valid) begin
               data_q <= data_d;
               cnt_q  <= cnt_q + 1'b1;
               if (cnt_q == LAST) begin
`ifdef SERIAL_LOADER_PARITY_EN
                  state_q <= PARITY;
`else
                  state_q <= WRITE;
                  we_q    <= 1'b1;
`endif
               end
            end
`ifdef SERIAL_LOADER_PARITY_EN
            PARITY: if (ser_valid) begin
               if (^{data_q, ser}) begin
                  par_err_q <= 1'b1;
                  cnt_q     <= '0;
                  state_q   <= SHIFT;
               end else begin
                  we_q    <= 1'b1;
                  state_q <= WRITE;
               end
            end
`endif
            WRITE: begin
               cnt_q      <= '0;
               word_cnt_q <= word_cnt_q + 1'b1;
               if (word_cnt_q == LAST_WORD) begin
                  state_q <= DONE;
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
               end else begin
                  state_q <= SHIFT;
                  addr_q  <= addr_q + 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end
   assign we       = we_q;
   assign addr     = addr_q;
   assign data     = data_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign word_cnt = word_cnt_q;
   assign par_err  = par_err_q;
endmodule

// File: doc/serial_loader.md
SERIAL_LOADER -- requirements
Module: serial_loader

Interface
REQ-001 SHALL provide parameter DATA_WIDTH, default 192, bits per assembled word (>= 2).
REQ-002 SHALL provide parameter ADDR_WIDTH, default 11, RAM write-address width.
REQ-003 SHALL provide parameter NUM_DP, default 5, words per load (1 .. 2**ADDR_WIDTH).
REQ-004 SHALL provide parameter MSB_FIRST, default 0, serial bit order (0 = LSB first, 1 = MSB first).
REQ-005 SHALL provide port CLK, input, 1, the single clock; all logic on its rising edge.
REQ-006 SHALL provide port RST, input, 1, synchronous active-high reset.
REQ-007 SHALL provide port start, input, 1, begins a load from IDLE or DONE.
REQ-008 SHALL provide port ser, input, 1, serial data bit.
REQ-009 SHALL provide port ser_valid, input, 1, ser is sampled only when this is 1.
REQ-010 SHALL provide port we, output, 1, RAM write strobe, one-cycle pulse per word.
REQ-011 SHALL provide port addr, output, ADDR_WIDTH, RAM write address.
REQ-012 SHALL provide port data, output, DATA_WIDTH, assembled word; valid while we=1.
REQ-013 SHALL provide port busy, output, 1, high in SHIFT, PARITY and WRITE.
REQ-014 SHALL provide port done, output, 1, high once NUM_DP words are written; held until restart or reset.
REQ-015 SHALL provide port word_cnt, output, ADDR_WIDTH+1, count of words written in the current load.
REQ-016 SHALL provide port par_err, output, 1, one-cycle parity-failure pulse.

Function
REQ-017 SHALL implement states IDLE, SHIFT, PARITY (macro only), WRITE, DONE; all outputs registered.
REQ-018 IDLE/DONE with start=1 SHALL go to SHIFT next cycle: bit counter 0, addr 0, word_cnt 0, done 0, busy 1.
REQ-019 SHIFT SHALL capture ser on each cycle with ser_valid=1 and hold all state when ser_valid=0.
REQ-020 With MSB_FIRST=0, the k-th valid bit (k from 0) SHALL land in data[k]; with MSB_FIRST=1, in data[DATA_WIDTH-1-k].
REQ-021 The bit counter SHALL be $clog2(DATA_WIDTH+1) wide and SHALL leave SHIFT on the cycle the DATA_WIDTH-th valid bit is sampled.
REQ-022 WRITE SHALL last exactly one cycle with we=1 and addr/data stable; we SHALL rise the cycle after the last data bit (or the parity bit) is sampled.
REQ-023 After WRITE, addr and word_cnt SHALL increment by 1; if word_cnt reaches NUM_DP the next state SHALL be DONE (done=1, busy=0, addr held at NUM_DP-1), otherwise SHIFT with bit counter 0.
REQ-024 ser_valid=1 during WRITE, IDLE or DONE SHALL be ignored; the source SHALL leave a one-cycle gap after each word.
REQ-025 start during SHIFT, PARITY or WRITE SHALL be ignored.
REQ-026 we SHALL never assert outside WRITE; par_err SHALL be 0 whenever the macro is absent.

Reset
REQ-027 RST=1 at a clock edge SHALL force IDLE and set we, addr, data, busy, done, word_cnt, par_err and the bit counter to 0, discarding any partial word.
REQ-028 RST SHALL take priority over start and ser_valid in the same cycle.

Configuration
REQ-029 Macro SERIAL_LOADER_PARITY_EN, when defined, SHALL add a PARITY state entered after DATA_WIDTH bits; the next valid bit is an even-parity bit over the word.
REQ-030 With SERIAL_LOADER_PARITY_EN, parity pass SHALL go to WRITE; parity fail SHALL pulse par_err one cycle, suppress we, keep addr/word_cnt, and return to SHIFT for the same slot.
REQ-031 Without SERIAL_LOADER_PARITY_EN, SHIFT SHALL go directly to WRITE and no PARITY state SHALL exist.

Verification (DATA_WIDTH=8, NUM_DP=3, ADDR_WIDTH=4)
REQ-032 start, then 0xA5, 0x3C, 0xFF LSB-first, continuous valid, one-cycle gaps -> we pulses at addr 0,1,2 with data A5,3C,FF; done=1 the cycle after the third we; word_cnt=3.
REQ-033 MSB_FIRST=1, bits 1,0,1,0,0,1,0,1 -> we with data=0xA5, addr=0.
REQ-034 ser_valid low 5 cycles mid-word -> data unchanged (0xA5); we delayed exactly 5 cycles.
REQ-035 RST high after 4 bits of word 1 -> next cycle all outputs 0, state IDLE; restart -> first we at addr 0.
REQ-036 Macro defined: 0xA5 + parity 0 -> we, addr 0; 0xA5 + parity 1 -> par_err one cycle, no we, addr stays 0.
REQ-037 start while in DONE -> done=0, busy=1 next cycle; the next load writes from addr 0.
